// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the byte-stream program loader.
//   state_t      : loader FSM states
//   SYNC_BYTE    : default frame start byte
//   HI_PAD_MASK  : bits of the HI byte that must be zero (only HI[0] is payload)
//   frame_words  : decodes the LEN byte into an instruction count (0 -> 256)
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LO,
        HI,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] HI_PAD_MASK = 8'hFE;

    // A LEN of zero encodes a full 256-word frame.
    function automatic logic [8:0] frame_words(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/loader_timer.sv
// -----------------------------------------------------------------------------
// loader_timer
// Inter-byte idle timer for the program loader.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous active-high reset
//   run    in  timer active (loader is inside a frame)
//   kick   in  a byte was accepted this cycle; restarts the idle count
//   expire out asserted during the TIMEOUT-th consecutive idle cycle while
//              running; never asserted together with kick, so an accept
//              arriving on the expiry cycle takes priority
// -----------------------------------------------------------------------------
module loader_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of idle cycles already elapsed before this one.
    assign expire = run && !kick && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!run || kick) begin
            cnt_d = '0;
        end else if (!expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Byte-stream program loader. Parses frames of the form
//   SYNC, LEN, {LO, HI} x N, [CSUM]
// and writes each 9-bit word {HI[0], LO} into the instruction RAM at
// addresses 0..N-1 while holding the core halted through `init`.
//
// Build option:
//   LOADER_CSUM_EN  defined   : a trailing CSUM byte (XOR of all payload bytes)
//                               is required and checked before releasing init.
//                   undefined : no CSUM byte; the frame completes after the
//                               last HI byte.
//
// Ports (all outputs registered):
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   in_valid    in   host byte valid
//   in_data     in   host byte
//   in_ready    out  loader accepts a byte this cycle (low during a RAM write)
//   imem_we     out  instruction RAM write enable, one-cycle pulse
//   imem_addr   out  instruction RAM write address
//   imem_wdata  out  instruction word
//   init        out  core halt, high whenever no successful load is in effect
//   load_done   out  last load completed successfully
//   load_err    out  last load aborted (bad pad bits, checksum or timeout)
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int         IW      = 8,
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    parameter int         TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          imem_we,
    output logic [IW-1:0] imem_addr,
    output logic [8:0]    imem_wdata,
    output logic          init,
    output logic          load_done,
    output logic          load_err
);

    state_t        state_q, state_d;
    logic [8:0]    n_q, n_d;           // words in this frame (1..256)
    logic [8:0]    count_q, count_d;   // words written so far
    logic [7:0]    lo_q, lo_d;
`ifdef LOADER_CSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif
    logic          rdy_q, rdy_d;
    logic          we_q, we_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [8:0]    wdata_q, wdata_d;
    logic          init_q, init_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic          timer_run;
    logic          expire;

    assign accept    = in_valid && rdy_q;
    assign timer_run = (state_q == LEN) || (state_q == LO) ||
                       (state_q == HI)  || (state_q == CSUM);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (timer_run),
        .kick   (accept),
        .expire (expire)
    );

    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        count_d = count_q;
        lo_d    = lo_q;
`ifdef LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        init_d  = init_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                // A SYNC byte (re)starts a load from any resting state;
                // everything else is discarded.
                if (accept && in_data == SYNC) begin
                    state_d = LEN;
                    count_d = '0;
`ifdef LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                    init_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            LEN: begin
                if (accept) begin
                    n_d     = frame_words(in_data);
                    state_d = LO;
                end
            end

            LO: begin
                if (accept) begin
                    lo_d    = in_data;
`ifdef LOADER_CSUM_EN
                    csum_d  = csum_q ^ in_data;
`endif
                    state_d = HI;
                end
            end

            HI: begin
                if (accept) begin
                    if ((in_data & HI_PAD_MASK) != 8'd0) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        init_d  = 1'b1;
                        done_d  = 1'b0;
                    end else begin
`ifdef LOADER_CSUM_EN
                        csum_d  = csum_q ^ in_data;
`endif
                        we_d    = 1'b1;
                        // count_q < 256 here, so the low byte is the address.
                        addr_d  = IW'(count_q[7:0]);
                        wdata_d = {in_data[0], lo_q};
                        count_d = count_q + 9'd1;
                        if (count_q + 9'd1 == n_q) begin
`ifdef LOADER_CSUM_EN
                            state_d = CSUM;
`else
                            state_d = DONE;
                            init_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = LO;
                        end
                    end
                end
            end

`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = DONE;
                        init_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        init_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
`endif

            default: begin
                state_d = ERR;
                err_d   = 1'b1;
                init_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase

        // expire is never high in an accept cycle, so it cannot override a byte.
        if (expire) begin
            state_d = ERR;
            err_d   = 1'b1;
            init_d  = 1'b1;
            done_d  = 1'b0;
        end

        // The RAM write slot and a new byte never share a cycle.
        rdy_d = !we_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            count_q <= '0;
            lo_q    <= '0;
`ifdef LOADER_CSUM_EN
            csum_q  <= '0;
`endif
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            init_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            count_q <= count_d;
            lo_q    <= lo_d;
`ifdef LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            init_q  <= init_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = rdy_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign init       = init_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader (TIMEOUT shortened to 16). Bytes are driven
// on the falling edge and all outputs are sampled on the falling edge.
// Works with LOADER_CSUM_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int IW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [IW-1:0] imem_addr;
    logic [8:0]    imem_wdata;
    logic          init;
    logic          load_done;
    logic          load_err;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] wr_addr[$];
    logic [8:0]    wr_data[$];

    prog_loader #(
        .IW      (IW),
        .SYNC    (8'hA5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .init       (init),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Log every RAM write; the write slot must never offer in_ready.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            check("rdy_in_we", {31'd0, in_ready}, 32'd0);
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("rdy_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_init"},  {31'd0, init},      32'd1);
        check({p, "_rdy"},   {31'd0, in_ready},  32'd0);
        check({p, "_we"},    {31'd0, imem_we},   32'd0);
        check({p, "_addr"},  {24'd0, imem_addr}, 32'd0);
        check({p, "_wdata"}, {23'd0, imem_wdata}, 32'd0);
        check({p, "_done"},  {31'd0, load_done}, 32'd0);
        check({p, "_err"},   {31'd0, load_err},  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] csum;
        logic [7:0] lo;
        logic [7:0] hi;

        // ---- reset state ----
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", {31'd0, in_ready}, 32'd1);

        // ---- two-word frame ----
        clear_log();
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h01);
        send_byte(8'h22); send_byte(8'h00);
`ifdef LOADER_CSUM_EN
        send_byte(8'h32);
`endif
        check("t1_init", {31'd0, init},      32'd0);
        check("t1_done", {31'd0, load_done}, 32'd1);
        check("t1_err",  {31'd0, load_err},  32'd0);
        idle(2);
        check("t1_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_a0", {24'd0, wr_addr[0]}, 32'h0);
            check("t1_d0", {23'd0, wr_data[0]}, 32'h111);
            check("t1_a1", {24'd0, wr_addr[1]}, 32'h1);
            check("t1_d1", {23'd0, wr_data[1]}, 32'h022);
        end

        // ---- garbage in DONE, restart, HI pad error ----
        clear_log();
        send_byte(8'h00);
        check("t2_keep_init", {31'd0, init}, 32'd0);
        send_byte(8'hA5);
        check("t2_restart_init", {31'd0, init},      32'd1);
        check("t2_restart_done", {31'd0, load_done}, 32'd0);
        send_byte(8'hA5);   // taken as LEN
        send_byte(8'h01);   // LO
        send_byte(8'hFF);   // HI with pad bits set
        send_byte(8'h03);   // discarded in ERR
        check("t2_err",  {31'd0, load_err},  32'd1);
        check("t2_init", {31'd0, init},      32'd1);
        check("t2_done", {31'd0, load_done}, 32'd0);
        idle(2);
        check("t2_nwr", wr_addr.size(), 32'd0);

        // ---- inter-byte timeout ----
        clear_log();
        send_byte(8'hA5);
        check("t3_sync_clr_err", {31'd0, load_err}, 32'd0);
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h00);
        idle(TIMEOUT - 1);
        check("t3_err_early", {31'd0, load_err}, 32'd0);
        idle(1);
        check("t3_err",  {31'd0, load_err}, 32'd1);
        check("t3_init", {31'd0, init},     32'd1);
        check("t3_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) check("t3_d0", {23'd0, wr_data[0]}, 32'h010);

        // ---- bad checksum (good frame when the checksum is not built in) ----
        clear_log();
        send_byte(8'hA5);
        check("t4_sync_clr_err", {31'd0, load_err}, 32'd0);
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h11);
`ifdef LOADER_CSUM_EN
        check("t4_err",  {31'd0, load_err},  32'd1);
        check("t4_done", {31'd0, load_done}, 32'd0);
        check("t4_init", {31'd0, init},      32'd1);
`else
        check("t4_err",  {31'd0, load_err},  32'd0);
        check("t4_done", {31'd0, load_done}, 32'd1);
        check("t4_init", {31'd0, init},      32'd0);
`endif
        idle(2);
        check("t4_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t4_a0", {24'd0, wr_addr[0]}, 32'h0);
            check("t4_d0", {23'd0, wr_data[0]}, 32'h010);
        end

        // ---- LEN=0 means 256 words ----
        clear_log();
        csum = 8'h00;
        send_byte(8'hA5); send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            lo = i[7:0];
            hi = {7'd0, i[0]};
            send_byte(lo);
            send_byte(hi);
            csum = csum ^ lo ^ hi;
        end
`ifdef LOADER_CSUM_EN
        send_byte(csum);
`endif
        check("t5_done", {31'd0, load_done}, 32'd1);
        check("t5_init", {31'd0, init},      32'd0);
        idle(2);
        check("t5_nwr", wr_addr.size(), 32'd256);
        if (wr_addr.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                check($sformatf("t5_a%0d", i), {24'd0, wr_addr[i]}, i);
                check($sformatf("t5_d%0d", i), {23'd0, wr_data[i]}, {23'd0, i[0], i[7:0]});
            end
            check("t5_last_addr", {24'd0, wr_addr[255]}, 32'hFF);
        end

        // ---- reset in the middle of a frame, then a clean load ----
        clear_log();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA);  // now waiting for HI
        reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'h01);
`ifdef LOADER_CSUM_EN
        send_byte(8'hAB);
`endif
        check("t6_done", {31'd0, load_done}, 32'd1);
        check("t6_init", {31'd0, init},      32'd0);
        idle(2);
        check("t6_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t6_a0", {24'd0, wr_addr[0]}, 32'h0);
            check("t6_d0", {23'd0, wr_data[0]}, 32'h1AA);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
